fp_max_reduce: RTL and testbench
================================

# fp_max_reduce

Streaming max/argmax reduction controller for the PNM datapath. It time-shares a single `fp_gt` comparator across a vector of IEEE-754 single-precision values delivered over a valid/ready stream. It returns the maximum value and the index of its first occurrence once per job. Typical use: max-pooling and softmax pre-scaling on rows read from near-memory banks.

## Interface
Parameters:
- `IDX_W`, 16: width of the length and index fields; maximum job length is 2^IDX_W − 1.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset. One clock; reset is synchronous and active-low.
- `start`, input, 1: job start pulse; sampled only in IDLE.
- `len`, input, IDX_W: element count for the job; captured when `start` is accepted.
- `busy`, output, 1: high in RUN and DONE.
- `in_valid`, input, 1: input element valid.
- `in_ready`, output, 1: block accepts an element this cycle.
- `in_data`, input, 32: fp32 element.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_max`, output, 32: maximum value.
- `out_idx`, output, IDX_W: zero-based index of the first occurrence of the maximum.
- `out_empty`, output, 1: the job had `len`=0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 with `len`≠0 captures `len`, clears `cnt`, and goes to RUN.
  - `start`=1 with `len`=0 goes to DONE with `out_max`=32'hFF80_0000 (−inf), `out_idx`=0, `out_empty`=1.
- RUN:
  - `in_ready`=1. A handshake (`in_valid`&&`in_ready`) is one element.
  - Element 0 loads `max_reg`←`in_data` and `idx_reg`←0 unconditionally.
  - Element k>0: if `fp_gt(in_data, max_reg)` then `max_reg`←`in_data` and `idx_reg`←k; otherwise both hold.
  - Ties keep the earlier index, so the first occurrence wins.
  - `cnt` increments per handshake. The handshake with `cnt`==`len_reg`−1 moves the FSM to DONE.
- DONE:
  - `out_valid`=1. `out_max`, `out_idx` and `out_empty` stay stable until `out_valid`&&`out_ready`.
  - On that handshake the FSM returns to IDLE and `out_empty` clears.
- `start` is ignored in RUN and DONE. `in_valid` is ignored outside RUN.
- Comparison semantics are exactly those of `fp_gt`; no NaN special-casing.
  - +0 beats −0.
  - +NaN beats +inf.
  - −NaN loses to −inf.

## Timing
- Reset values: FSM=IDLE; `busy`=0, `in_ready`=0, `out_valid`=0, `out_max`=0, `out_idx`=0, `out_empty`=0; `cnt`, `len_reg`, `max_reg`, `idx_reg` all 0.
- `start` accepted at edge T: `busy` and `in_ready` are high from T+1.
- Throughput: one element per cycle with no bubbles. The comparator is combinational between `in_data` and `max_reg`.
- Last element accepted at edge T: `in_ready`=0 and `out_valid`=1 from T+1. Latency from last input to result is 1 cycle.
- `out_ready` held high: DONE lasts exactly 1 cycle, and IDLE follows.
- A `start` in the IDLE cycle right after DONE is accepted, giving a minimum of 2 dead cycles between jobs.
- `len`=0: `start` at T gives `out_valid` at T+1.
- `rst_n`=0 at any edge, including mid-RUN or in DONE with `out_ready`=0: partial results are discarded, all state returns to reset values on that edge, and no result is emitted.
- `cnt` never wraps. `len_reg` ≤ 2^IDX_W − 1 bounds it.

## Structure
- Shared package `pnm_fp_pkg`:
  - `FP_NEG_INF`=32'hFF80_0000.
  - `FP_W`=32.
  - FSM state enum `fmr_state_t` {IDLE, RUN, DONE}.
- One sub-module: an instance of the existing `fp_gt` (a=`in_data`, b=`max_reg`).
- Everything else lives in one file: FSM, counter, and the result registers.

## Test plan
- **Basic:** `len`=4, stream {3.0=0x40400000, −1.0=0xBF800000, 7.5=0x40F00000, 2.0=0x40000000} back-to-back → `out_max`=0x40F00000, `out_idx`=2, `out_valid` 1 cycle after 4th handshake.
- **Ties and sign:**
  - `len`=3, {−0=0x80000000, +0=0x00000000, +0} → `out_max`=0x00000000, `out_idx`=1.
  - `len`=2, {5.0, 5.0} → `out_idx`=0.
- **All negative with backpressure:** `len`=3, {−2.0, −0.5, −8.0}, `in_valid` toggling every other cycle and `out_ready` held low for 5 cycles → `out_max`=0xBF000000, `out_idx`=1, outputs stable while stalled.
- **Empty job:** `len`=0 → next cycle `out_valid`=1, `out_empty`=1, `out_max`=0xFF800000, `out_idx`=0; `in_ready` never asserts.
- **Reset mid-job:** `len`=8, reset after 3 handshakes → all outputs 0 the next cycle, FSM=IDLE; a new job with `len`=1 and element 1.0 returns 0x3F800000, idx 0.
- **Protocol:** `start` pulsed during RUN and DONE is ignored (result unchanged). Back-to-back jobs (`len`=1 each) start in the first IDLE cycle after the result handshake.

Source files
------------

// File: rtl/pnm_fp_pkg.sv
// Shared constants and types for the PNM fp32 reduction datapath.
package pnm_fp_pkg;

    localparam int          FP_W       = 32;
    localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fmr_state_t;

endpackage

// File: rtl/fp_gt.sv
// fp32 strict greater-than on the raw sign-magnitude encoding.
// No NaN special-casing: +NaN sits above +inf, -NaN below -inf, and +0 above -0.
module fp_gt
    import pnm_fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            gt
);

    always_comb begin
        gt = 1'b0;
        if (a[FP_W-1] != b[FP_W-1]) begin
            gt = b[FP_W-1];
        end else if (!a[FP_W-1]) begin
            gt = (a[FP_W-2:0] > b[FP_W-2:0]);
        end else begin
            // Both negative: the larger magnitude is the smaller value.
            gt = (a[FP_W-2:0] < b[FP_W-2:0]);
        end
    end

endmodule

// File: rtl/fp_max_reduce.sv
// Streaming max/argmax over a valid/ready stream of fp32 values, one job at a time,
// sharing a single combinational fp_gt between the incoming element and the running max.
module fp_max_reduce
    import pnm_fp_pkg::*;
#(
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_empty
);

    fmr_state_t       state_q;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] len_q;
    logic [FP_W-1:0]  max_q;
    logic [IDX_W-1:0] idx_q;
    logic             empty_q;
    logic             busy_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             in_gt;
    logic             in_hs;
    logic             last_hs;
    logic             take_d;

    fp_gt u_fp_gt (
        .a  (in_data),
        .b  (max_q),
        .gt (in_gt)
    );

    assign in_hs   = in_valid && in_ready_q;
    assign last_hs = in_hs && (cnt_q == IDX_W'(len_q - 1'b1));
    // Element 0 seeds the running max regardless of its value.
    assign take_d  = (cnt_q == '0) || in_gt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            empty_q     <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (len != '0) begin
                            len_q      <= len;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b1;
                            state_q    <= RUN;
                        end else begin
                            max_q       <= FP_NEG_INF;
                            idx_q       <= '0;
                            empty_q     <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (in_hs) begin
                        if (take_d) begin
                            max_q <= in_data;
                            idx_q <= cnt_q;
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (last_hs) begin
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                        empty_q     <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_max   = max_q;
    assign out_idx   = idx_q;
    assign out_empty = empty_q;

endmodule

// File: tb/tb_fp_max_reduce.sv
// Directed plus randomized bench for fp_max_reduce against an order-key reference model.
module tb_fp_max_reduce;

    localparam int IDX_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [IDX_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_max;
    logic [IDX_W-1:0] out_idx;
    logic             out_empty;

    int vectors;
    int miscompares;

    logic [31:0] job_q[$];
    logic [31:0] pool [9] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
                              32'hFF80_0000, 32'h7FC0_0000, 32'hFFC0_0000,
                              32'h3F80_0000, 32'hBF80_0000, 32'h40A0_0000};

    fp_max_reduce #(.IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_empty (out_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Map fp32 bit patterns onto an unsigned key whose order is the comparison order.
    function automatic logic [31:0] order_key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    task automatic ref_model(input int n, output logic [31:0] emax,
                             output logic [IDX_W-1:0] eidx, output logic eempty);
        emax   = 32'hFF80_0000;
        eidx   = '0;
        eempty = (n == 0);
        for (int i = 0; i < n; i++) begin
            if (i == 0 || order_key(job_q[i]) > order_key(emax)) begin
                emax = job_q[i];
                eidx = IDX_W'(i);
            end
        end
    endtask

    task automatic run_job(input int n, input bit gaps, input int stall, input bit poke);
        logic [31:0]      emax;
        logic [IDX_W-1:0] eidx;
        logic             eempty;
        int               k;
        int               cyc;
        bit               hs;
        ref_model(n, emax, eidx, eempty);
        start = 1'b1;
        len   = IDX_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        len   = IDX_W'($urandom);
        check("busy_after_start", busy, 1'b1);
        check("in_ready_after_start", in_ready, n != 0);
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 4 * n + 20) begin
            in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            in_data  = in_valid ? job_q[k] : $urandom;
            if (poke && k == 1) begin
                start = 1'b1;
                len   = '0;
            end
            hs = in_valid && in_ready;
            check("in_ready_run", in_ready, 1'b1);
            @(posedge clk); #1;
            if (hs) k++;
            cyc++;
        end
        in_valid = 1'b0;
        if (k < n) check("elements_accepted", k, n);
        check("out_valid_done", out_valid, 1'b1);
        check("in_ready_done", in_ready, 1'b0);
        check("busy_done", busy, 1'b1);
        check("out_max", out_max, emax);
        check("out_idx", out_idx, eidx);
        check("out_empty", out_empty, eempty);
        if (poke) begin
            start = 1'b1;
            len   = 16'd3;
        end
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_max", out_max, emax);
            check("stall_idx", out_idx, eidx);
            check("stall_empty", out_empty, eempty);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b0;
        check("idle_valid", out_valid, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_empty", out_empty, 1'b0);
        check("idle_in_ready", in_ready, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        len         = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_max", out_max, 32'h0);
        check("rst_out_idx", out_idx, 16'h0);
        check("rst_out_empty", out_empty, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic stream
        job_q = '{32'h4040_0000, 32'hBF80_0000, 32'h40F0_0000, 32'h4000_0000};
        run_job(4, 1'b0, 0, 1'b0);
        check("basic_max_const", out_max, 32'h40F0_0000);
        check("basic_idx_const", out_idx, 16'd2);

        // Ties and signed zeros
        job_q = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
        run_job(3, 1'b0, 1, 1'b0);
        job_q = '{32'h40A0_0000, 32'h40A0_0000};
        run_job(2, 1'b0, 0, 1'b0);

        // All negative with input gaps and output stall
        job_q = '{32'hC000_0000, 32'hBF00_0000, 32'hC100_0000};
        run_job(3, 1'b1, 5, 1'b0);

        // Empty job
        job_q = {};
        run_job(0, 1'b0, 2, 1'b0);

        // NaN and infinity ordering
        job_q = '{32'h7F80_0000, 32'h7FC0_0000, 32'hFF80_0000};
        run_job(3, 1'b0, 0, 1'b0);
        job_q = '{32'hFF80_0000, 32'hFFC0_0000};
        run_job(2, 1'b0, 0, 1'b0);

        // Reset in the middle of a job
        start = 1'b1;
        len   = 16'd8;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h4100_0000 + 32'(i);
            @(posedge clk); #1;
        end
        in_data = 32'h4200_0000;
        rst_n   = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_max", out_max, 32'h0);
        check("midrst_out_idx", out_idx, 16'h0);
        check("midrst_out_empty", out_empty, 1'b0);
        job_q = '{32'h3F80_0000};
        run_job(1, 1'b0, 0, 1'b0);

        // Reset while holding a result
        job_q = '{32'h4000_0000, 32'h4100_0000};
        start = 1'b1;
        len   = 16'd2;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = job_q[0];
        @(posedge clk); #1;
        in_data = job_q[1];
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("donerst_out_valid", out_valid, 1'b0);
        check("donerst_out_max", out_max, 32'h0);

        // start pulses during RUN and DONE must be ignored
        job_q = '{32'h3F00_0000, 32'h4080_0000, 32'h3E80_0000};
        run_job(3, 1'b0, 2, 1'b1);
        job_q = '{32'hC080_0000};
        run_job(1, 1'b0, 1, 1'b1);

        // Back-to-back single-element jobs
        for (int j = 0; j < 3; j++) begin
            job_q = '{$urandom};
            run_job(1, 1'b0, 0, 1'b0);
        end

        // Randomized jobs
        for (int j = 0; j < 24; j++) begin
            int n;
            n     = $urandom_range(1, 12);
            job_q = {};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) job_q.push_back($urandom);
                else job_q.push_back(pool[$urandom_range(0, 8)]);
            end
            run_job(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
